// File: rtl/ibis_fb_arbiter.sv
// Framebuffer port arbiter: per-hblank prefetch of the next visible line into a
// double-buffered line buffer, host traffic in between, sticky underrun on a missed deadline.
module ibis_fb_arbiter #(
  parameter int WIDTH      = 10,
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 160,
  parameter int Y_ACTIVE   = 480,
  parameter int Y_TOTAL    = 525,
  parameter int FB_BASE    = 0,
  parameter int MAX_OUT    = 4
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic                          hblank,
  input  logic                          vblank,
  input  logic [WIDTH-1:0]              ord_y,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          host_we,
  input  logic [ADDR_WIDTH-1:0]         host_addr,
  input  logic [DATA_WIDTH-1:0]         host_wdata,
  output logic                          host_rvalid,
  output logic [DATA_WIDTH-1:0]         host_rdata,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_we,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic [DATA_WIDTH-1:0]         mem_req_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
  output logic                          line_wr_valid,
  output logic [$clog2(LINE_WORDS):0]   line_wr_addr,
  output logic [DATA_WIDTH-1:0]         line_wr_data,
  output logic                          busy,
  output logic                          underrun,
  input  logic                          underrun_clr
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int OW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {IDLE, H2V, VIDEO, VWAIT} state_t;

  state_t                  state, state_nxt;
  logic                    hblank_q, rise, fall;
  logic                    vpend, owner_video, bank, start, rd_acc, out_ok;
  logic [WIDTH-1:0]        nxt;
  logic [ADDR_WIDTH-1:0]   base, base_calc;
  logic [IW-1:0]           issue_cnt, rsp_count;
  logic [OW-1:0]           outstanding;
  logic                    unused;

  // vblank is carried for status only; nothing here is sequenced from it
  assign unused = vblank;

  assign rise      = hblank & ~hblank_q;
  assign fall      = ~hblank & hblank_q;
  assign nxt       = (ord_y == WIDTH'(Y_TOTAL - 1)) ? '0 : ord_y + WIDTH'(1);
  assign start     = rise & enable & ~vpend & (int'(nxt) < Y_ACTIVE);
  assign base_calc = ADDR_WIDTH'(FB_BASE + int'(nxt) * LINE_WORDS);
  assign out_ok    = outstanding < OW'(MAX_OUT);
  assign rd_acc    = mem_req_valid & mem_req_ready & ~mem_req_we;
  assign busy      = vpend;

  // Responses come back in order and the owner only changes once drained, so no tags
  assign host_rvalid = mem_rsp_valid & ~owner_video;
  assign host_rdata  = mem_rsp_data;

  always_comb begin
    state_nxt     = state;
    host_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = host_addr;
    mem_req_wdata = host_wdata;
    case (state)
      IDLE: begin
        if (aresetn && !vpend) begin
          host_ready    = mem_req_ready & (host_we | out_ok);
          mem_req_valid = host_valid & (host_we | out_ok);
          mem_req_we    = host_we;
        end
        if (vpend) state_nxt = H2V;
      end
      H2V: begin
        if (fall)                   state_nxt = VWAIT;
        else if (outstanding == '0) state_nxt = VIDEO;
      end
      VIDEO: begin
        mem_req_valid = out_ok;
        mem_req_addr  = base + ADDR_WIDTH'(issue_cnt);
        mem_req_wdata = '0;
        if (fall) state_nxt = VWAIT;
        else if (mem_req_valid && mem_req_ready && issue_cnt == IW'(LINE_WORDS - 1))
          state_nxt = VWAIT;
      end
      VWAIT: begin
        if (outstanding == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      hblank_q      <= 1'b1;
      vpend         <= 1'b0;
      owner_video   <= 1'b0;
      bank          <= 1'b0;
      base          <= '0;
      issue_cnt     <= '0;
      rsp_count     <= '0;
      outstanding   <= '0;
      underrun      <= 1'b0;
      line_wr_valid <= 1'b0;
      line_wr_addr  <= '0;
      line_wr_data  <= '0;
    end else begin
      state    <= state_nxt;
      hblank_q <= hblank;

      if (start) begin
        vpend     <= 1'b1;
        bank      <= nxt[0];
        base      <= base_calc;
        issue_cnt <= '0;
        rsp_count <= '0;
      end else if (state == VWAIT && state_nxt == IDLE) begin
        vpend <= 1'b0;
      end

      if (state == H2V && state_nxt == VIDEO)       owner_video <= 1'b1;
      else if (state == VWAIT && state_nxt == IDLE) owner_video <= 1'b0;

      if (state == VIDEO && mem_req_valid && mem_req_ready)
        issue_cnt <= issue_cnt + IW'(1);

      if (rd_acc && !mem_rsp_valid)      outstanding <= outstanding + OW'(1);
      else if (!rd_acc && mem_rsp_valid) outstanding <= outstanding - OW'(1);

      // A deadline miss in the same cycle as a clear leaves the flag set
      if ((state == H2V || state == VIDEO) && fall) underrun <= 1'b1;
      else if (underrun_clr)                        underrun <= 1'b0;

      line_wr_valid <= mem_rsp_valid & owner_video;
      if (mem_rsp_valid && owner_video) begin
        line_wr_addr <= {bank, rsp_count};
        line_wr_data <= mem_rsp_data;
        rsp_count    <= rsp_count + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ibis_fb_arbiter.sv
// Directed bench for ibis_fb_arbiter with an in-order, fixed-latency memory model.
module tb_ibis_fb_arbiter;
  localparam int AW = 18;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn, enable, hblank, vblank;
  logic [9:0]    ord_y;
  logic          host_valid, host_ready, host_we, host_rvalid;
  logic [AW-1:0] host_addr, mem_req_addr;
  logic [DW-1:0] host_wdata, host_rdata, mem_req_wdata, line_wr_data;
  logic          mem_req_valid, mem_req_ready, mem_req_we;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rsp_data  = '0;
  logic          line_wr_valid;
  logic [8:0]    line_wr_addr;
  logic          busy, underrun, underrun_clr;

  ibis_fb_arbiter dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .hblank(hblank), .vblank(vblank),
    .ord_y(ord_y), .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .line_wr_valid(line_wr_valid), .line_wr_addr(line_wr_addr), .line_wr_data(line_wr_data),
    .busy(busy), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, lat = 3, tb_out = 0, max_out = 0;
  bit busy_seen = 1'b0;

  logic [AW-1:0] acc_addr[$];
  logic          acc_we[$];
  int            acc_cyc[$];
  int            rq_due[$];
  logic [AW-1:0] rq_addr[$];
  logic [8:0]    lw_addr[$];
  logic [DW-1:0] lw_data[$];
  int            hr_cyc[$];
  logic [DW-1:0] hr_data[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {14'h1ABC, a};
  endfunction

  always @(posedge aclk) begin
    if (aresetn === 1'b1) begin
      if (mem_req_valid && mem_req_ready) begin
        acc_addr.push_back(mem_req_addr);
        acc_we.push_back(mem_req_we);
        acc_cyc.push_back(cyc);
        if (!mem_req_we) begin
          rq_due.push_back(cyc + lat);
          rq_addr.push_back(mem_req_addr);
          tb_out++;
        end
      end
      if (mem_rsp_valid) tb_out--;
      if (tb_out > max_out) max_out = tb_out;
      if (line_wr_valid) begin
        lw_addr.push_back(line_wr_addr);
        lw_data.push_back(line_wr_data);
      end
      if (host_rvalid) begin
        hr_cyc.push_back(cyc);
        hr_data.push_back(host_rdata);
      end
      if (busy) busy_seen = 1'b1;
    end
    cyc++;
  end

  always @(negedge aclk) begin
    if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(rq_addr[0]);
      void'(rq_due.pop_front());
      void'(rq_addr.pop_front());
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  task automatic clear_logs();
    acc_addr.delete(); acc_we.delete(); acc_cyc.delete();
    lw_addr.delete(); lw_data.delete(); hr_cyc.delete(); hr_data.delete();
    busy_seen = 1'b0;
    max_out   = 0;
  endtask

  task automatic run_hblank(input int y, input int hb, output logic busy_end);
    @(negedge aclk);
    ord_y  = 10'(y);
    hblank = 1'b1;
    repeat (hb - 1) @(negedge aclk);
    busy_end = busy;
    hblank   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      if (!busy && tb_out == 0 && rq_due.size() == 0 && !mem_rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_reset();
    logic [4:0] o;
    aresetn = 1'b0; enable = 1'b1; hblank = 1'b1; vblank = 1'b0; ord_y = 10'd9;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 18'd5; host_wdata = '0;
    mem_req_ready = 1'b1; underrun_clr = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (host_ready !== 1'b0) begin errors++; $display("FAIL reset_host_ready got %0b want 0", host_ready); end
    checks++;
    if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got %0b want 0", mem_req_valid); end
    o = {busy, underrun, line_wr_valid, host_rvalid, mem_req_we};
    checks++;
    if (o !== 5'b0) begin errors++; $display("FAIL reset_outputs got %b want 00000", o); end
    // hblank still high at release must not look like a rising edge
    host_valid = 1'b0;
    aresetn    = 1'b1;
    repeat (4) @(negedge aclk);
    checks++;
    if (busy_seen !== 1'b0 || acc_addr.size() != 0) begin
      errors++; $display("FAIL reset_no_spurious_fetch got busy_seen=%0b reqs=%0d want 0 0", busy_seen, acc_addr.size());
    end
    hblank = 1'b0;
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_fetch_line9();
    logic be; bit ok; int bad;
    lat = 3; mem_req_ready = 1'b1;
    clear_logs();
    run_hblank(9, 300, be);
    wait_idle(200, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL l9_drain got timeout want idle"); end
    checks++;
    if (acc_addr.size() != 160) begin errors++; $display("FAIL l9_req_count got %0d want 160", acc_addr.size()); end
    bad = 0;
    for (int i = 0; i < acc_addr.size(); i++)
      if (acc_addr[i] !== AW'(1600 + i) || acc_we[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL l9_req_addr got %0d bad want 0", bad); end
    checks++;
    if (lw_addr.size() != 160) begin errors++; $display("FAIL l9_lw_count got %0d want 160", lw_addr.size()); end
    bad = 0;
    for (int i = 0; i < lw_addr.size(); i++)
      if (lw_addr[i] !== 9'(i) || lw_data[i] !== mem_word(AW'(1600 + i))) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL l9_lw_data got %0d bad want 0", bad); end
    checks++;
    if (busy_seen !== 1'b1 || be !== 1'b0) begin
      errors++; $display("FAIL l9_busy got seen=%0b at_fall=%0b want 1 0", busy_seen, be);
    end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL l9_underrun got %0b want 0", underrun); end
  endtask

  task automatic test_line_wrap();
    logic be; bit ok; int bad;
    clear_logs();
    run_hblank(479, 50, be);
    wait_idle(50, ok);
    checks++;
    if (acc_addr.size() != 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL y479_no_fetch got reqs=%0d busy_seen=%0b want 0 0", acc_addr.size(), busy_seen);
    end
    enable = 1'b0;
    run_hblank(100, 50, be);
    wait_idle(50, ok);
    enable = 1'b1;
    checks++;
    if (acc_addr.size() != 0 || busy_seen !== 1'b0) begin
      errors++; $display("FAIL disabled_no_fetch got reqs=%0d busy_seen=%0b want 0 0", acc_addr.size(), busy_seen);
    end
    clear_logs();
    run_hblank(524, 300, be);
    wait_idle(200, ok);
    bad = (acc_addr.size() == 160 && lw_addr.size() == 160) ? 0 : 1000;
    for (int i = 0; i < acc_addr.size(); i++) if (acc_addr[i] !== AW'(i)) bad++;
    for (int i = 0; i < lw_addr.size(); i++)
      if (lw_addr[i] !== 9'(i) || lw_data[i] !== mem_word(AW'(i))) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL y524_line0 got %0d bad (reqs=%0d lw=%0d) want 0", bad, acc_addr.size(), lw_addr.size()); end
    clear_logs();
    run_hblank(10, 300, be);
    wait_idle(200, ok);
    bad = (acc_addr.size() == 160 && lw_addr.size() == 160) ? 0 : 1000;
    for (int i = 0; i < acc_addr.size(); i++) if (acc_addr[i] !== AW'(1760 + i)) bad++;
    for (int i = 0; i < lw_addr.size(); i++) if (lw_addr[i] !== 9'(256 + i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL y10_bank1 got %0d bad (reqs=%0d lw=%0d) want 0", bad, acc_addr.size(), lw_addr.size()); end
  endtask

  task automatic test_host_preempt();
    bit ok, got; int bad;
    lat = 3; mem_req_ready = 1'b1;
    clear_logs();
    got = 1'b0;
    @(negedge aclk);
    host_valid = 1'b1; host_we = 1'b0; host_addr = 18'h100;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin errors++; $display("FAIL hp_ready_idle got %0b want 1", host_ready); end
    @(negedge aclk);
    host_addr = 18'h101;
    @(negedge aclk);
    host_valid = 1'b0; ord_y = 10'd20; hblank = 1'b1;
    @(negedge aclk);
    host_valid = 1'b1; host_addr = 18'h102;
    #1;
    checks++;
    if (host_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL hp_ready_drop got ready=%0b req=%0b want 0 0", host_ready, mem_req_valid);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge aclk);
      if (got) host_valid = 1'b0;
      if (i == 296) hblank = 1'b0;
      #1;
      if (!got && host_valid && host_ready) got = 1'b1;
    end
    host_valid = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL hp_resume got accepted=%0b want 1", got); end
    checks++;
    if (acc_addr.size() != 163) begin errors++; $display("FAIL hp_req_count got %0d want 163", acc_addr.size()); end
    checks++;
    if (hr_cyc.size() != 3) begin errors++; $display("FAIL hp_rvalid_count got %0d want 3", hr_cyc.size()); end
    if (acc_addr.size() == 163 && hr_cyc.size() == 3) begin
      bad = 0;
      if (acc_addr[0] !== 18'h100 || acc_addr[1] !== 18'h101 || acc_addr[162] !== 18'h102) bad++;
      for (int i = 2; i < 162; i++) if (acc_addr[i] !== AW'(3360 + i - 2) || acc_we[i] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hp_req_order got %0d bad want 0", bad); end
      checks++;
      if (acc_cyc[2] <= hr_cyc[1]) begin
        errors++; $display("FAIL hp_video_after_host got video@%0d host_rsp@%0d want video later", acc_cyc[2], hr_cyc[1]);
      end
      checks++;
      if (hr_data[0] !== mem_word(18'h100) || hr_data[1] !== mem_word(18'h101) || hr_data[2] !== mem_word(18'h102)) begin
        errors++; $display("FAIL hp_rdata got %h %h %h want %h %h %h", hr_data[0], hr_data[1], hr_data[2],
                           mem_word(18'h100), mem_word(18'h101), mem_word(18'h102));
      end
    end
    checks++;
    if (lw_addr.size() != 160) begin errors++; $display("FAIL hp_lw_count got %0d want 160", lw_addr.size()); end
  endtask

  task automatic test_underrun();
    logic be; bit ok;
    clear_logs();
    mem_req_ready = 1'b0;
    run_hblank(30, 800, be);
    checks++;
    if (be !== 1'b1 || underrun !== 1'b0) begin
      errors++; $display("FAIL ur_before_fall got busy=%0b underrun=%0b want 1 0", be, underrun);
    end
    repeat (3) @(negedge aclk);
    checks++;
    if (underrun !== 1'b1 || busy !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL ur_after_fall got underrun=%0b busy=%0b req=%0b want 1 0 0", underrun, busy, mem_req_valid);
    end
    mem_req_ready = 1'b1;
    repeat (20) @(negedge aclk);
    checks++;
    if (acc_addr.size() != 0 || lw_addr.size() != 0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL ur_cancelled got reqs=%0d lw=%0d host_ready=%0b want 0 0 1", acc_addr.size(), lw_addr.size(), host_ready);
    end
    underrun_clr = 1'b1;
    @(negedge aclk);
    underrun_clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear got %0b want 0", underrun); end
    // set and clear in the same cycle: set wins, the held clear takes effect a cycle later
    mem_req_ready = 1'b0;
    underrun_clr  = 1'b1;
    run_hblank(31, 10, be);
    @(negedge aclk);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins got %0b want 1", underrun); end
    @(negedge aclk);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear_after got %0b want 0", underrun); end
    underrun_clr  = 1'b0;
    mem_req_ready = 1'b1;
    wait_idle(50, ok);
  endtask

  task automatic test_slow_mem();
    logic be; bit ok; int bad;
    lat = 20; mem_req_ready = 1'b1;
    clear_logs();
    run_hblank(40, 1000, be);
    wait_idle(300, ok);
    checks++;
    if (max_out != 4) begin errors++; $display("FAIL slow_max_outstanding got %0d want 4", max_out); end
    checks++;
    if (lw_addr.size() != 160) begin errors++; $display("FAIL slow_lw_count got %0d want 160", lw_addr.size()); end
    bad = 0;
    for (int i = 0; i < lw_addr.size(); i++)
      if (lw_addr[i] !== 9'(256 + i) || lw_data[i] !== mem_word(AW'(6560 + i))) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL slow_lw_order got %0d bad want 0", bad); end
    checks++;
    if (underrun !== 1'b0 || be !== 1'b0 || ok !== 1'b1) begin
      errors++; $display("FAIL slow_deadline got underrun=%0b busy_at_fall=%0b idle=%0b want 0 0 1", underrun, be, ok);
    end
    lat = 3;
  endtask

  initial begin
    test_reset();
    test_fetch_line9();
    test_line_wrap();
    test_host_preempt();
    test_underrun();
    test_slow_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibis_fb_arbiter.md
Name: ibis_fb_arbiter

Overview:
Shares the single framebuffer memory port between the video scanline prefetcher and a host (CPU/blitter) requester.
- Sequenced by the VGA timing block's hblank/vblank/ord_y outputs.
- On each hblank rising edge it fetches the next visible line into a double-buffered line buffer, with priority over the host.
- The host is served at all other times.
- A missed line deadline is flagged as underrun.

Parameters:
WIDTH, 10, width of ord_y (matches the timing block).
ADDR_WIDTH, 18, framebuffer word address width.
DATA_WIDTH, 32, memory word width.
LINE_WORDS, 160, memory words per active line (640 px, 4 px/word).
Y_ACTIVE, 480, visible lines.
Y_TOTAL, 525, total lines per frame; last line index is Y_TOTAL-1.
FB_BASE, 0, framebuffer base word address.
MAX_OUT, 4, maximum outstanding memory reads.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
enable  in  1  gates scheduling of new line fetches
hblank  in  1  from timing block
vblank  in  1  from timing block (status only)
ord_y  in  WIDTH  current line from timing block
host_valid  in  1  host request valid
host_ready  out  1  host request accepted when valid&ready
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_WIDTH  host word address
host_wdata  in  DATA_WIDTH  host write data
host_rvalid  out  1  host read data valid
host_rdata  out  DATA_WIDTH  host read data
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  write strobe
mem_req_addr  out  ADDR_WIDTH  memory address
mem_req_wdata  out  DATA_WIDTH  memory write data
mem_rsp_valid  in  1  read data valid; responses in request order, none for writes
mem_rsp_data  in  DATA_WIDTH  read data
line_wr_valid  out  1  line buffer write strobe
line_wr_addr  out  clog2(LINE_WORDS)+1  {bank, word index}
line_wr_data  out  DATA_WIDTH  line buffer data
busy  out  1  video fetch in progress
underrun  out  1  sticky deadline-miss flag
underrun_clr  in  1  clears underrun

Behaviour:
- Reset (aresetn=0 at posedge aclk): state IDLE; all out-valids, host_ready, busy, underrun = 0; counters 0; hblank edge register = 1 (no spurious edge after reset). Reset mid-transaction abandons everything; the memory is reset in the same domain.
- Edge detect: hblank registered each cycle. Rise = hblank & ~hblank_q. On rise with enable=1: nxt = (ord_y==Y_TOTAL-1) ? 0 : ord_y+1. If nxt<Y_ACTIVE, set vpend (registered) and latch nxt.
- Base address = FB_BASE + nxt*LINE_WORDS, truncated to ADDR_WIDTH. Bank = nxt[0].
- Outstanding counter: +1 on accepted read, -1 on mem_rsp_valid; both in one cycle leaves it unchanged. New reads issue only if outstanding<MAX_OUT.
- States:
  - IDLE/HOST: owner=host.
    - mem_req_* mirror host_* combinationally.
    - host_ready = mem_req_ready & ~vpend & (host_we | outstanding<MAX_OUT).
    - When vpend=1, go to H2V.
  - H2V: no new host requests. When outstanding==0, go to VIDEO.
  - VIDEO: owner=video, issue reads base+0..base+LINE_WORDS-1, one per accepted handshake, mem_req_we=0. After the last accept, go to VWAIT.
  - VWAIT: when outstanding==0, clear vpend and go to IDLE.
- Response routing: owner at issue time holds until drained, so no tags are used.
  - Host responses pass through combinationally: host_rvalid = mem_rsp_valid & owner host.
  - Video responses are registered, 1-cycle latency: line_wr_valid, line_wr_addr = {bank, rsp_count}, rsp_count increments per response.
- busy = 1 from vpend set until VWAIT exits.
- Deadline: hblank falling while state is H2V or VIDEO sets underrun.
  - Remaining issues are cancelled; go to VWAIT. Outstanding responses are still written.
  - underrun_clr clears the flag; a set in the same cycle wins.
- A hblank rise while busy (cannot happen with legal timing) is ignored.
- enable=0 blocks new fetches only; in-flight work completes.

Test Plan:
- Reset held 3 cycles with host_valid=1 -> all outputs 0, host_ready 0, no mem_req_valid.
- ord_y=9, hblank rise, mem_req_ready=1, read latency 3 -> 160 reads at addr 1600..1759; line_wr_addr 0..159 in bank 0; busy falls before hblank falls; underrun=0.
- ord_y=479 hblank rise -> no fetch. ord_y=524 hblank rise -> line 0 fetched from addr 0, bank 0.
- Host issues 2 reads, then hblank rises -> host_ready drops the next cycle; first video request appears only after both host_rvalid pulses; host resumes after VWAIT.
- mem_req_ready=0 throughout hblank (800 cycles) -> underrun=1 at hblank fall, no further video requests, IDLE after drain; underrun_clr -> 0.
- Memory response delay 20 cycles -> outstanding never exceeds 4; all 160 line words still written in order.
